// File: rtl/alu_console.sv
// alu_console: button-driven ALU with a sequential shift-add multiplier and a
// small circular history of stored results.
//
// state | meaning
// IDLE  | waiting for an execute press; loads and history stepping accepted
// MUL   | shift-add multiply, one multiplier bit per cycle, busy=1
// DONE  | multiply finished; result and flags are written this cycle
module alu_console #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         sw,
  input  logic                     enA,
  input  logic                     enB,
  input  logic                     enO,
  input  logic                     enS,
  input  logic                     enH,
  output logic [WIDTH-1:0]         a_q,
  output logic [WIDTH-1:0]         b_q,
  output logic [3:0]               op_q,
  output logic [WIDTH-1:0]         s_q,
  output logic [3:0]               flags,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] hist_idx,
  output logic [WIDTH-1:0]         hist_q,
  output logic [3:0]               LEDs
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  // Button order in the vectors below: {enH, enS, enO, enB, enA}
  logic [4:0] sync1_q, sync2_q, prev_q, press_q;
  logic [4:0] btn;

  state_t                 state_q;
  logic [2*WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]       mplier_q;
  logic [BIT_W-1:0]       bit_cnt_q;

  logic [WIDTH-1:0]       hist_mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [PTR_W-1:0]       hist_idx_q;
  logic [PTR_W-1:0]       rd_idx;

  logic                   idle;
  logic                   go_a, go_b, go_o, go_s, go_h;
  logic [WIDTH:0]         add_ext, sub_ext;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c, alu_v;
  logic [3:0]             alu_flags, mul_flags;
  logic                   wr_en;
  logic [WIDTH-1:0]       wr_data;
  logic [3:0]             wr_flags;

  assign btn = {enH, enS, enO, enB, enA};

  // Two-flop synchroniser plus a registered falling-edge detect per button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      press_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= prev_q & ~sync2_q;
    end
  end

  // The whole multiply sequence counts as busy, so operand/execute presses
  // landing in DONE are dropped too rather than racing the DONE write.
  assign idle = (state_q == IDLE);
  assign go_a = press_q[0] & idle;
  assign go_b = press_q[1] & idle;
  assign go_o = press_q[2] & idle;
  assign go_s = press_q[3] & idle;
  assign go_h = press_q[4];

  assign add_ext = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext = {1'b0, a_q} - {1'b0, b_q};

  // Single-cycle ALU result and carry/overflow from the current registers
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      4'd0: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd1: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd2: alu_res = a_q & b_q;
      4'd3: alu_res = a_q | b_q;
      4'd4: alu_res = a_q ^ b_q;
      4'd5: alu_res = ~a_q;
      4'd6: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
      end
      4'd7: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  assign alu_flags = {alu_v, alu_res[WIDTH-1], alu_c, ~|alu_res};
  assign mul_flags = {1'b0, acc_q[WIDTH-1], |acc_q[2*WIDTH-1:WIDTH], ~|acc_q[WIDTH-1:0]};

  // Select which result, if any, is stored this cycle
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = '0;
    wr_flags = '0;
    if (state_q == DONE) begin
      wr_en    = 1'b1;
      wr_data  = acc_q[WIDTH-1:0];
      wr_flags = mul_flags;
    end else if (go_s && (op_q != OP_MUL)) begin
      wr_en    = 1'b1;
      wr_data  = alu_res;
      wr_flags = alu_flags;
    end
  end

  // Operand and opcode loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (go_a) a_q  <= sw;
      if (go_b) b_q  <= sw;
      if (go_o) op_q <= sw[3:0];
    end
  end

  // Execute/multiply FSM with registered busy, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      s_q       <= '0;
      flags     <= '0;
    end else begin
      if (wr_en) begin
        s_q   <= wr_data;
        flags <= wr_flags;
      end
      case (state_q)
        IDLE: begin
          busy <= 1'b0;
          if (go_s && (op_q == OP_MUL)) begin
            state_q   <= MUL;
            busy      <= 1'b1;
            mcand_q   <= {{WIDTH{1'b0}}, a_q};
            mplier_q  <= b_q;
            acc_q     <= '0;
            bit_cnt_q <= BIT_W'(WIDTH);
          end
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          if (bit_cnt_q == BIT_W'(1)) begin
            state_q <= DONE;
            busy    <= 1'b0;
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Result history: circular buffer with saturating fill count and view index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hist_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      hist_idx_q <= '0;
    end else if (wr_en) begin
      hist_mem_q[wr_ptr_q] <= wr_data;
      wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      hist_idx_q <= '0;
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end else if (go_h && (count_q != '0)) begin
      if (({1'b0, hist_idx_q} + CNT_W'(1)) == count_q) hist_idx_q <= '0;
      else hist_idx_q <= hist_idx_q + PTR_W'(1);
    end
  end

  // DEPTH is a power of two, so pointer arithmetic wraps modulo DEPTH for free
  assign rd_idx   = wr_ptr_q - PTR_W'(1) - hist_idx_q;
  assign hist_q   = (count_q == '0) ? '0 : hist_mem_q[rd_idx];
  assign hist_idx = hist_idx_q;
  assign LEDs     = op_q;

endmodule

// File: tb/tb_alu_console.sv
// Self-checking bench for alu_console: directed scenarios plus randomized
// operations compared against a behavioural model kept in this file.
module tb_alu_console;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk, rst_n;
  logic [W-1:0] sw;
  logic         enA, enB, enO, enS, enH;
  logic [W-1:0] a_q, b_q, s_q, hist_q;
  logic [3:0]   op_q, flags, LEDs;
  logic         busy;
  logic [1:0]   hist_idx;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int m_a, m_b, m_op, m_s;
  logic [3:0] m_fl;
  int hq[$];
  int m_hidx;

  alu_console #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .enA(enA), .enB(enB), .enO(enO), .enS(enS), .enH(enH),
    .a_q(a_q), .b_q(b_q), .op_q(op_q), .s_q(s_q), .flags(flags),
    .busy(busy), .hist_idx(hist_idx), .hist_q(hist_q), .LEDs(LEDs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int res, output logic [3:0] fl);
    int full, sr;
    logic c, v;
    c = 1'b0; v = 1'b0; res = 0;
    case (op)
      0: begin full = a + b; res = full % 256; c = (full > 255);
               sr = sgn(a) + sgn(b); v = (sr > 127) || (sr < -128); end
      1: begin res = (a - b + 256) % 256; c = (a < b);
               sr = sgn(a) - sgn(b); v = (sr > 127) || (sr < -128); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: begin res = (a * 2) % 256; c = (a >= 128); end
      7: begin res = a / 2; c = (a % 2 == 1); end
      8: begin full = a * b; res = full % 256; c = (full > 255); end
      default: res = 0;
    endcase
    fl = {v, (res >= 128), c, (res == 0)};
  endfunction

  function automatic int exp_hist();
    return (hq.size() == 0) ? 0 : hq[m_hidx];
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_s = 0; m_fl = 4'b0000;
    hq.delete(); m_hidx = 0;
  endtask

  task automatic model_store(input int res, input logic [3:0] fl);
    m_s = res; m_fl = fl;
    hq.push_front(res);
    if (hq.size() > D) void'(hq.pop_back());
    m_hidx = 0;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: enA = v;
      1: enB = v;
      2: enO = v;
      3: enS = v;
      default: enH = v;
    endcase
  endtask

  // hold a button low for three cycles, release, and let things settle
  task automatic btn(input int which);
    set_btn(which, 1'b0);
    repeat (3) @(negedge clk);
    set_btn(which, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic load(input int which, input int v);
    sw = W'(v);
    btn(which);
    case (which)
      0: m_a = v;
      1: m_b = v;
      default: m_op = v % 16;
    endcase
  endtask

  task automatic exec();
    int r; logic [3:0] f;
    ref_alu(m_op, m_a, m_b, r, f);
    btn(3);
    if (m_op == 8) repeat (W + 4) @(negedge clk);
    model_store(r, f);
  endtask

  task automatic step_hist();
    btn(4);
    if (hq.size() > 0) m_hidx = (m_hidx + 1) % hq.size();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({a_q, b_q, op_q, s_q, flags, busy, hist_idx, hist_q, LEDs} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got a=%h b=%h op=%h s=%h fl=%b busy=%b hidx=%0d hist=%h leds=%h, expected all zero",
               a_q, b_q, op_q, s_q, flags, busy, hist_idx, hist_q, LEDs);
    end
  endtask

  task automatic test_add_overflow();
    load(0, 8'h7F); load(1, 8'h01); load(2, 0); exec();
    n_checks++;
    if (s_q !== 8'h80 || flags !== 4'b1100) begin
      n_errors++;
      $display("FAIL add_overflow: got s=%h fl=%b, expected s=80 fl=1100", s_q, flags);
    end
  endtask

  task automatic test_sub_borrow();
    load(0, 0); load(1, 1); load(2, 1); exec();
    n_checks++;
    if (s_q !== 8'hFF || flags !== 4'b0110) begin
      n_errors++;
      $display("FAIL sub_borrow: got s=%h fl=%b, expected s=ff fl=0110", s_q, flags);
    end
  endtask

  task automatic test_hold();
    int loads;
    logic [W-1:0] prev;
    do_reset();
    sw = 8'h11; enA = 1'b0;
    loads = 0; prev = a_q;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_q !== prev) loads++;
      prev = a_q;
      if (i == 2) begin
        n_checks++;
        if (a_q !== 8'h00) begin
          n_errors++;
          $display("FAIL hold_early: got a=%h after edge 2, expected 00", a_q);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (a_q !== 8'h11) begin
          n_errors++;
          $display("FAIL hold_edge3: got a=%h after edge 3, expected 11", a_q);
        end
      end
      if (i == 9) sw = 8'h22;
    end
    enA = 1'b1;
    repeat (4) @(negedge clk);
    m_a = 8'h11;
    n_checks++;
    if (a_q !== 8'h11 || loads != 1) begin
      n_errors++;
      $display("FAIL hold_once: got a=%h loads=%0d, expected a=11 loads=1", a_q, loads);
    end
  endtask

  task automatic test_mul();
    int nbusy;
    load(0, 8'h10); load(1, 8'h10); load(2, 8);
    nbusy = 0;
    enS = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (i == 2) enS = 1'b1;
      if (i == 4) begin sw = 8'h77; enA = 1'b0; end
      if (i == 7) enA = 1'b1;
    end
    model_store(0, 4'b0011);
    n_checks++;
    if (nbusy != W) begin
      n_errors++;
      $display("FAIL mul_busy_cycles: got %0d, expected %0d", nbusy, W);
    end
    n_checks++;
    if (s_q !== 8'h00 || flags !== 4'b0011) begin
      n_errors++;
      $display("FAIL mul_result: got s=%h fl=%b, expected s=00 fl=0011", s_q, flags);
    end
    n_checks++;
    if (a_q !== 8'h10) begin
      n_errors++;
      $display("FAIL mul_ignore_enA: got a=%h, expected 10", a_q);
    end
  endtask

  task automatic test_history();
    logic [W-1:0] want [5] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd5};
    do_reset();
    load(1, 0); load(2, 0);
    for (int k = 1; k <= 5; k++) begin
      load(0, k); exec();
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hist_q !== want[i] || hist_q !== W'(exp_hist())) begin
        n_errors++;
        $display("FAIL history_step%0d: got hist=%h, expected %h", i, hist_q, want[i]);
      end
      step_hist();
    end
  endtask

  task automatic test_reset_mid_mul();
    int r; logic [3:0] f;
    load(0, $urandom_range(1, 255)); load(1, $urandom_range(1, 255)); load(2, 8);
    enS = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({a_q, b_q, op_q, s_q, flags, busy, hist_idx, hist_q, LEDs} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_mul: got a=%h b=%h op=%h s=%h fl=%b busy=%b hist=%h, expected all zero",
               a_q, b_q, op_q, s_q, flags, busy, hist_q);
    end
    enS = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || s_q !== 8'h00 || hist_q !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_no_phantom: got busy=%b s=%h hist=%h, expected 0 00 00", busy, s_q, hist_q);
    end
    load(0, $urandom_range(0, 255)); load(1, $urandom_range(0, 255)); load(2, 8);
    ref_alu(m_op, m_a, m_b, r, f);
    exec();
    n_checks++;
    if (s_q !== W'(r) || flags !== f || hist_q !== W'(r)) begin
      n_errors++;
      $display("FAIL mul_after_reset: got s=%h fl=%b hist=%h, expected s=%h fl=%b", s_q, flags, hist_q, W'(r), f);
    end
  endtask

  task automatic test_back_to_back();
    load(0, 3); load(1, 4); load(2, 0);
    sw = 8'h50; enA = 1'b0; enS = 1'b0;
    repeat (3) @(negedge clk);
    enA = 1'b1; enS = 1'b1;
    repeat (4) @(negedge clk);
    model_store(7, 4'b0000);
    m_a = 8'h50;
    n_checks++;
    if (s_q !== 8'h07 || a_q !== 8'h50 || flags !== 4'b0000) begin
      n_errors++;
      $display("FAIL simultaneous_load_exec: got s=%h a=%h fl=%b, expected s=07 a=50 fl=0000", s_q, a_q, flags);
    end
  endtask

  task automatic test_random_ops();
    int op;
    for (int it = 0; it < 30; it++) begin
      op = ($urandom_range(0, 3) == 0) ? 8 : $urandom_range(0, 15);
      load(0, $urandom_range(0, 255));
      load(1, $urandom_range(0, 255));
      load(2, op);
      if ($urandom_range(0, 1) == 1) begin
        step_hist();
        n_checks++;
        if (hist_q !== W'(exp_hist())) begin
          n_errors++;
          $display("FAIL rand_hist_step it%0d: got %h, expected %h", it, hist_q, W'(exp_hist()));
        end
      end
      exec();
      n_checks++;
      if (s_q !== W'(m_s) || flags !== m_fl || op_q !== 4'(m_op) || LEDs !== 4'(m_op)
          || a_q !== W'(m_a) || b_q !== W'(m_b) || hist_q !== W'(exp_hist()) || hist_idx !== 2'd0) begin
        n_errors++;
        $display("FAIL rand_op it%0d op=%0d a=%h b=%h: got s=%h fl=%b leds=%h hist=%h hidx=%0d, expected s=%h fl=%b hist=%h",
                 it, m_op, W'(m_a), W'(m_b), s_q, flags, LEDs, hist_q, hist_idx, W'(m_s), m_fl, W'(exp_hist()));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sw = '0;
    enA = 1'b1; enB = 1'b1; enO = 1'b1; enS = 1'b1; enH = 1'b1;
    model_reset();
    test_reset();
    test_add_overflow();
    test_sub_borrow();
    test_hold();
    test_mul();
    test_history();
    test_reset_mid_mul();
    test_back_to_back();
    test_random_ops();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_console.md
ALU_CONSOLE -- requirements
Module: alu_console

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8, operand/result width (>=2).
- DEPTH, default 4, result history entries (power of 2, >=2).

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- sw  in  WIDTH  switch data for A/B loads; sw[3:0] for op load.
- enA  in  1  active-low button: load A.
- enB  in  1  active-low button: load B.
- enO  in  1  active-low button: load opcode.
- enS  in  1  active-low button: execute and store result.
- enH  in  1  active-low button: step history view.
- a_q  out  WIDTH  operand A register.
- b_q  out  WIDTH  operand B register.
- op_q  out  4  opcode register.
- s_q  out  WIDTH  result register.
- flags  out  4  {V,N,C,Z} of last stored result.
- busy  out  1  multiply in progress.
- hist_idx  out  $clog2(DEPTH)  history view index; 0 = newest.
- hist_q  out  WIDTH  history entry selected by hist_idx.
- LEDs  out  4  equals op_q.

Function
REQ-003 Each button SHALL pass a 2-FF synchroniser; a press SHALL be a synchronised 1->0 transition, so a held button acts exactly once.
REQ-004 Register update SHALL occur on the edge after press detection: stable low input at edge 0 -> register updated at edge 3.
REQ-005 Press enA/enB SHALL load sw into a_q/b_q; press enO SHALL load sw[3:0] into op_q.
REQ-006 Press enS SHALL evaluate using register values held before that edge; simultaneous enA/enB/enO presses SHALL load but not affect that evaluation.
REQ-007 Opcodes SHALL be:
- 0 A+B; 1 A-B; 2 A&B; 3 A|B; 4 A^B; 5 ~A;
- 6 A<<1; 7 A>>1 (logical); 8 A*B low WIDTH bits;
- 9-15 result 0, flags Z=1 only.
REQ-008 Flags SHALL be:
- Z: result==0. N: result MSB.
- C: carry-out (add); borrow, A<B unsigned (sub); bit shifted out (6,7); upper product nonzero (8); else 0.
- V: signed overflow for add/sub, else 0.
REQ-009 Ops 0-7 and 9-15 SHALL write s_q and flags one edge after detection.
REQ-010 Op 8 SHALL use FSM IDLE->MUL->DONE->IDLE: operands snapshotted on entry; shift-add one bit per cycle; busy=1 for exactly WIDTH cycles in MUL; DONE writes s_q/flags, busy=0.
REQ-011 While busy, presses of enA, enB, enO, enS SHALL be discarded; enH SHALL remain active.
REQ-012 Each s_q write SHALL push into a DEPTH-entry circular buffer at wr_ptr:
- wr_ptr wraps DEPTH-1 -> 0.
- count saturates at DEPTH; oldest entry overwritten.
REQ-013 hist_q SHALL equal entry (wr_ptr-1-hist_idx) mod DEPTH; 0 when count==0.
REQ-014 Press enH SHALL advance hist_idx modulo count (no change when count==0); any s_q write SHALL clear hist_idx to 0, overriding a same-cycle enH.

Reset
REQ-015 rst_n low SHALL immediately clear:
- a_q, b_q, op_q, s_q, flags, busy, hist_idx, hist_q, wr_ptr, count, history entries: 0.
- FSM: IDLE. Synchroniser/edge flops: 1 (released).
REQ-016 Reset during MUL SHALL abort it with no result written; no press SHALL be detected on the first edges after release while buttons remain high.

Verification
REQ-017 Bench SHALL cover:
- Load A=0x7F, B=0x01, op=0, press enS -> s_q=0x80, flags V=1,N=1,C=0,Z=0.
- Hold enA low 20 cycles, sw changes 0x11->0x22 at cycle 10 -> a_q=0x11, loaded once at edge 3.
- A=0x10, B=0x10, op=8, enS -> busy high 8 cycles, s_q=0x00, C=1, Z=1; enA press mid-op ignored.
- Five results 1..5 with DEPTH=4 -> hist_q, stepping enH: 5,4,3,2,5; count=4.
- rst_n low at MUL cycle 3 -> all outputs 0, busy=0; next enS completes normally.
- op=1, A=0x00, B=0x01 -> s_q=0xFF, C=1, N=1, V=0.
